// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a single-port data memory with one-cycle registered reads.
// Port 0 has priority; port 1 is served after at most MAX_BURST consecutive port-0 grants.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dataIn,
    output logic              mem_memoryEnable,
    output logic              mem_readNotWrite,
    input  logic [DATA_W-1:0] mem_dataOut,
    output logic              dbg_state
);

    // Handshake: a port holds req/we/addr/wdata stable until its gnt is seen high
    // in a cycle; that cycle is the issue cycle. rvalid pulses for one cycle per read.

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    typedef enum logic {
        IDLE   = 1'b0,
        RDWAIT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               can_issue;
    logic               pick1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            burst_cnt_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rdata_q     <= rdata_d;
        end
    end

    // Gating on reset keeps grants and memory strobes quiet while reset is held.
    assign can_issue = reset && (state_q == IDLE);
    assign pick1     = req1 && (!req0 || (burst_cnt_q == BURST_LIMIT));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (gnt0 && !we0) begin
                    state_d = RDWAIT;
                    owner_d = 1'b0;
                end else if (gnt1 && !we1) begin
                    state_d = RDWAIT;
                    owner_d = 1'b1;
                end
            end
            RDWAIT: begin
                state_d = IDLE;
                rdata_d = mem_dataOut;
            end
            default: state_d = IDLE;
        endcase
        if (!req1 || gnt1) begin
            burst_cnt_d = '0;
        end else if (gnt0 && (burst_cnt_q != BURST_LIMIT)) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    always_comb begin
        gnt0             = 1'b0;
        gnt1             = 1'b0;
        mem_addr         = '0;
        mem_dataIn       = '0;
        mem_memoryEnable = 1'b0;
        mem_readNotWrite = 1'b1;
        if (can_issue) begin
            if (pick1) begin
                gnt1             = 1'b1;
                mem_addr         = addr1;
                mem_dataIn       = wdata1;
                mem_memoryEnable = 1'b1;
                mem_readNotWrite = ~we1;
            end else if (req0) begin
                gnt0             = 1'b1;
                mem_addr         = addr0;
                mem_dataIn       = wdata0;
                mem_memoryEnable = 1'b1;
                mem_readNotWrite = ~we0;
            end
        end
        // Routing follows the registered owner, not the live request lines.
        rvalid0 = (state_q == RDWAIT) && !owner_q;
        rvalid1 = (state_q == RDWAIT) && owner_q;
        if (!reset || (state_q == RDWAIT)) begin
            rdata = mem_dataOut;
        end else begin
            rdata = rdata_q;
        end
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory attached.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata, mem_addr, mem_dataIn, mem_dataOut;
    logic        mem_memoryEnable, mem_readNotWrite, dbg_state;

    logic [31:0] mem [16];
    logic [31:0] exp_mem [16];
    logic [31:0] exp_q [$];
    int          n_chk;
    int          n_fail;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata),
        .mem_addr(mem_addr), .mem_dataIn(mem_dataIn),
        .mem_memoryEnable(mem_memoryEnable), .mem_readNotWrite(mem_readNotWrite),
        .mem_dataOut(mem_dataOut),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory writes on any edge with readNotWrite low, so stray writes show up.
    always @(posedge clk) begin
        if (!mem_readNotWrite) begin
            mem[mem_addr[3:0]] <= mem_dataIn;
        end else if (mem_memoryEnable) begin
            mem_dataOut <= mem[mem_addr[3:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, "_en"}, 32'(mem_memoryEnable), 32'd0);
        chk({tag, "_rnw"}, 32'(mem_readNotWrite), 32'd1);
        chk({tag, "_addr"}, mem_addr, 32'd0);
    endtask

    task automatic chk_read_data(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, rdata, e);
        end
    endtask

    int pat [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 32'h1000 + 32'(i);
            exp_mem[i] = 32'h1000 + 32'(i);
        end
        mem_dataOut = 32'h0;
        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd3; wdata0 = 32'h0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 32'h0;

        // reset held with a pending port-0 request
        repeat (2) @(posedge clk);
        mid();
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk_idle_bus("rst");
        tick();
        reset = 1'b1;
        mid();
        chk("rel_gnt0", 32'(gnt0), 32'd1);
        exp_q.push_back(32'h1003);
        tick();
        req0 = 1'b0;
        mid();
        chk("rel_rvalid0", 32'(rvalid0), 32'd1);
        chk("rel_state", 32'(dbg_state), 32'd1);
        chk_read_data("rel_rdata");
        tick();

        // port-0 write then read of address 5
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd5; wdata0 = 32'hDEADBEEF;
        mid();
        chk("wr5_gnt0", 32'(gnt0), 32'd1);
        chk("wr5_rnw", 32'(mem_readNotWrite), 32'd0);
        chk("wr5_addr", mem_addr, 32'd5);
        chk("wr5_din", mem_dataIn, 32'hDEADBEEF);
        exp_mem[5] = 32'hDEADBEEF;
        tick();
        we0 = 1'b0;
        mid();
        chk("rd5_gnt0", 32'(gnt0), 32'd1);
        chk("rd5_rnw", 32'(mem_readNotWrite), 32'd1);
        chk("rd5_en", 32'(mem_memoryEnable), 32'd1);
        exp_q.push_back(32'hDEADBEEF);
        tick();
        req0 = 1'b0;
        mid();
        chk("rd5_rvalid0", 32'(rvalid0), 32'd1);
        chk("rd5_rvalid1", 32'(rvalid1), 32'd0);
        chk("rd5_gnt0_wait", 32'(gnt0), 32'd0);
        chk("rd5_en_wait", 32'(mem_memoryEnable), 32'd0);
        chk_read_data("rd5_rdata");
        tick();
        mid();
        chk("rd5_rvalid0_off", 32'(rvalid0), 32'd0);
        chk("rd5_rdata_hold", rdata, 32'hDEADBEEF);
        chk_idle_bus("after_rd5");
        tick();

        // back-to-back writes 0..3 then readback
        for (int i = 0; i < 4; i++) begin
            req0 = 1'b1; we0 = 1'b1; addr0 = 32'(i); wdata0 = 32'hA0 + 32'(i);
            exp_mem[i] = 32'hA0 + 32'(i);
            mid();
            chk("b2b_gnt0", 32'(gnt0), 32'd1);
            chk("b2b_rnw", 32'(mem_readNotWrite), 32'd0);
            tick();
        end
        req0 = 1'b0; we0 = 1'b0;
        mid();
        chk("b2b_end_gnt0", 32'(gnt0), 32'd0);
        chk_idle_bus("b2b_end");
        tick();
        for (int i = 0; i < 4; i++) begin
            req0 = 1'b1; we0 = 1'b0; addr0 = 32'(i);
            mid();
            chk("rb_gnt0", 32'(gnt0), 32'd1);
            exp_q.push_back(32'hA0 + 32'(i));
            tick();
            req0 = 1'b0;
            mid();
            chk("rb_rvalid0", 32'(rvalid0), 32'd1);
            chk_read_data("rb_rdata");
            tick();
        end

        // both ports writing continuously: burst limit forces port 1 in
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd8; wdata0 = 32'h0808_0808;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd9; wdata1 = 32'h0909_0909;
        exp_mem[8] = 32'h0808_0808;
        exp_mem[9] = 32'h0909_0909;
        for (int i = 0; i < 10; i++) begin
            mid();
            chk("burst_gnt1", 32'(gnt1), 32'(pat[i]));
            chk("burst_gnt0", 32'(gnt0), 32'(1 - pat[i]));
            chk("burst_rnw", 32'(mem_readNotWrite), 32'd0);
            tick();
        end
        req0 = 1'b0; we0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
        tick();

        // port-1 read raised while port-0 read is waiting
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
        mid();
        chk("ov_gnt0", 32'(gnt0), 32'd1);
        exp_q.push_back(32'hDEADBEEF);
        tick();
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd7;
        mid();
        chk("ov_rvalid0", 32'(rvalid0), 32'd1);
        chk("ov_gnt1_wait", 32'(gnt1), 32'd0);
        chk("ov_rvalid1_early", 32'(rvalid1), 32'd0);
        chk_read_data("ov_rdata0");
        tick();
        mid();
        chk("ov_gnt1", 32'(gnt1), 32'd1);
        chk("ov_addr", mem_addr, 32'd7);
        chk("ov_rvalid0_off", 32'(rvalid0), 32'd0);
        exp_q.push_back(32'h1007);
        tick();
        req1 = 1'b0;
        mid();
        chk("ov_rvalid1", 32'(rvalid1), 32'd1);
        chk("ov_rvalid0_excl", 32'(rvalid0), 32'd0);
        chk_read_data("ov_rdata1");
        tick();

        // reset asserted during port-1 read wait
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd2;
        mid();
        chk("rr_gnt1", 32'(gnt1), 32'd1);
        tick();
        req1 = 1'b0;
        mid();
        chk("rr_rvalid1", 32'(rvalid1), 32'd1);
        chk("rr_rdata", rdata, 32'hA2);
        #1;
        reset = 1'b0;
        #1;
        chk("rr_rvalid1_drop", 32'(rvalid1), 32'd0);
        chk("rr_rdata_pass", rdata, 32'hA2);
        tick();
        mid();
        chk("rr_rvalid1_held", 32'(rvalid1), 32'd0);
        chk_idle_bus("rr_in_reset");
        tick();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mid();
            chk("rr_post_rvalid1", 32'(rvalid1), 32'd0);
            chk("rr_post_gnt1", 32'(gnt1), 32'd0);
            chk_idle_bus("rr_post");
            tick();
        end

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("mem_%0d", i), mem[i], exp_mem[i]);
        end
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
